// File: rtl/data_memory_unit.sv
// -----------------------------------------------------------------------------
// data_memory_unit
//
// Multi-cycle data memory responder at the far end of the DMWr/DMCtrl
// interface. It accepts one load/store request per valid/ready handshake and
// performs a byte, half or word access on a word-wide array. Sub-word stores
// use read-modify-write. Load data is sign- or zero-extended. Misaligned
// accesses are flagged and never touch the array.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the array (power of two)
//   IDX_W        word-index width; word index = Address[IDX_W+1:2]
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset (array contents kept)
//   req_valid     request present
//   req_ready     unit idle, can accept a request
//   Address       byte address
//   DataWr        store data, byte/half taken from the low bits
//   DMWr          1 = store, 0 = load
//   DMCtrl        000 B, 001 H, 010 W, 100 BU, 101 HU, others = no access
//   resp_valid    response available, held until resp_ready
//   resp_ready    consumer takes the response
//   DataRd        load result, 0 for stores / no-access / faults
//   access_fault  response is a fault (qualified by resp_valid)
//
// Build option
//   DMEM_RANGE_CHECK_EN  when defined, an access with any address bit above
//                        the array range set faults (takes priority over the
//                        misalignment check). When undefined, those bits are
//                        ignored and the address aliases into the array.
// -----------------------------------------------------------------------------
module data_memory_unit #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   input  logic        DMWr,
   input  logic [2:0]  DMCtrl,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] DataRd,
   output logic        access_fault
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W+1:0]  addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic              fault_q, fault_d;
   logic [31:0]       rd_word_q;

   logic [31:0]       mem [DEPTH_WORDS];

   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic [31:0]       merged_word;
   logic [31:0]       load_data;
   logic              range_err;

   logic [1:0]        lane;
   logic [IDX_W-1:0]  word_idx;

   assign lane     = addr_q[1:0];
   assign word_idx = addr_q[IDX_W+1:2];

   // -------------------------------------------------------------------------
   // Access-code helpers
   // -------------------------------------------------------------------------
   function automatic logic code_valid(input logic [2:0] c);
      logic v;
      case (c)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: v = 1'b1;
         default:                                v = 1'b0;
      endcase
      return v;
   endfunction

   // Only meaningful for valid codes; size is carried in c[1:0].
   function automatic logic misaligned(input logic [2:0] c, input logic [1:0] a);
      logic m;
      case (c[1:0])
         2'b01:   m = a[0];
         2'b10:   m = (a != 2'b00);
         default: m = 1'b0;
      endcase
      return m;
   endfunction

`ifdef DMEM_RANGE_CHECK_EN
   assign range_err = |Address[31:IDX_W+2];
`else
   logic addr_hi_unused;
   assign addr_hi_unused = |Address[31:IDX_W+2];
   assign range_err      = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      ctrl_d  = ctrl_q;
      fault_d = fault_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = Address[IDX_W+1:0];
               wdata_d = DataWr;
               wr_d    = DMWr;
               ctrl_d  = DMCtrl;
               fault_d = 1'b0;
               if (range_err) begin
                  fault_d = 1'b1;
                  state_d = S_RESP;
               end else if (!code_valid(DMCtrl)) begin
                  state_d = S_RESP;
               end else if (misaligned(DMCtrl, Address[1:0])) begin
                  fault_d = 1'b1;
                  state_d = S_RESP;
               end else if (DMWr && (DMCtrl[1:0] == 2'b10)) begin
                  state_d = S_WRITE;
               end else begin
                  // Loads and sub-word stores both read the word first.
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            state_d = wr_q ? S_WRITE : S_RESP;
         end
         S_WRITE: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         ctrl_q  <= 3'b111;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         ctrl_q  <= ctrl_d;
         fault_q <= fault_d;
      end
   end

   // -------------------------------------------------------------------------
   // Store data path: full word for SW, lane merge into the read word otherwise.
   // BU/HU codes on a store behave as SB/SH, so size comes from ctrl[1:0].
   // -------------------------------------------------------------------------
   always_comb begin
      merged_word = rd_word_q;
      if (ctrl_q[1:0] == 2'b00) begin
         merged_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      end else if (lane[1]) begin
         merged_word[31:16] = wdata_q[15:0];
      end else begin
         merged_word[15:0] = wdata_q[15:0];
      end
   end

   assign mem_wdata = (ctrl_q[1:0] == 2'b10) ? wdata_q : merged_word;

   // A reset coinciding with the WRITE edge must leave the array untouched.
   assign mem_we = (state_q == S_WRITE) && !rst;

   // The array itself has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[word_idx] <= mem_wdata;
      end
      if (state_q == S_READ) begin
         rd_word_q <= mem[word_idx];
      end
   end

   // -------------------------------------------------------------------------
   // Load data path
   // -------------------------------------------------------------------------
   always_comb begin
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      byte_v    = rd_word_q[{lane, 3'b000} +: 8];
      half_v    = lane[1] ? rd_word_q[31:16] : rd_word_q[15:0];
      load_data = '0;
      case (ctrl_q)
         3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
         3'b001:  load_data = {{16{half_v[15]}}, half_v};
         3'b010:  load_data = rd_word_q;
         3'b100:  load_data = {24'h000000, byte_v};
         3'b101:  load_data = {16'h0000, half_v};
         default: load_data = '0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs: everything is derived from registered state, so the response
   // stays stable for as long as the unit sits in RESP.
   // -------------------------------------------------------------------------
   assign req_ready    = (state_q == S_IDLE);
   assign resp_valid   = (state_q == S_RESP);
   assign access_fault = resp_valid && fault_q;
   assign DataRd       = (resp_valid && !wr_q && !fault_q) ? load_data : '0;

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

   localparam int unsigned DEPTH = 1024;

   localparam logic [2:0] C_B    = 3'b000;
   localparam logic [2:0] C_H    = 3'b001;
   localparam logic [2:0] C_W    = 3'b010;
   localparam logic [2:0] C_BU   = 3'b100;
   localparam logic [2:0] C_HU   = 3'b101;
   localparam logic [2:0] C_NONE = 3'b111;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] Address;
   logic [31:0] DataWr;
   logic        DMWr;
   logic [2:0]  DMCtrl;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] DataRd;
   logic        access_fault;

   int unsigned n_tests;
   int unsigned n_fail;

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int unsigned lat;
   } exp_t;

   exp_t sb[$];

   data_memory_unit #(.DEPTH_WORDS(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .Address      (Address),
      .DataWr       (DataWr),
      .DMWr         (DMWr),
      .DMCtrl       (DMCtrl),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .DataRd       (DataRd),
      .access_fault (access_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One request/response transaction. Called at a negedge with the unit idle;
   // returns at a negedge after the response handshake. Request inputs are
   // scrambled right after the accept edge so only the latched copies matter.
   task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic wr, input logic [2:0] ctrl,
                      input logic [31:0] exp_data, input logic exp_fault,
                      input int unsigned exp_lat, input int unsigned hold);
      exp_t        e;
      exp_t        got;
      int unsigned lat;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      Address   = addr;
      DataWr    = wdata;
      DMWr      = wr;
      DMCtrl    = ctrl;
      e.data    = exp_data;
      e.fault   = exp_fault;
      e.lat     = exp_lat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      Address   = $urandom;
      DataWr    = $urandom;
      DMWr      = 1'($urandom);
      DMCtrl    = 3'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 20);
      got = sb.pop_front();
      check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".latency"}, lat, got.lat);
      check({tag, ".DataRd"}, DataRd, got.data);
      check({tag, ".fault"}, 32'(access_fault), 32'(got.fault));
      // Back-pressure: response must hold, and a pending request is ignored.
      for (int i = 0; i < int'(hold); i++) begin
         req_valid = 1'b1;
         @(negedge clk);
         check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
         check({tag, ".hold_data"}, DataRd, got.data);
         check({tag, ".hold_fault"}, 32'(access_fault), 32'(got.fault));
         check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check({tag, ".resp_drop"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      Address    = '0;
      DataWr     = '0;
      DMWr       = 1'b0;
      DMCtrl     = C_NONE;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);

      check("reset.req_ready", 32'(req_ready), 32'd1);
      check("reset.resp_valid", 32'(resp_valid), 32'd0);
      check("reset.DataRd", DataRd, 32'd0);
      check("reset.fault", 32'(access_fault), 32'd0);

      // Word store / load
      txn("sw10", 32'h10, 32'hDEADBEEF, 1'b1, C_W, 32'h0, 1'b0, 2, 0);
      txn("lw10", 32'h10, 32'h0, 1'b0, C_W, 32'hDEADBEEF, 1'b0, 2, 0);

      // Byte store by read-modify-write, then byte loads
      txn("sb11", 32'h11, 32'h000000AA, 1'b1, C_B, 32'h0, 1'b0, 3, 0);
      txn("lw10b", 32'h10, 32'h0, 1'b0, C_W, 32'hDEADAAEF, 1'b0, 2, 0);
      txn("lb11", 32'h11, 32'h0, 1'b0, C_B, 32'hFFFFFFAA, 1'b0, 2, 0);
      txn("lbu11", 32'h11, 32'h0, 1'b0, C_BU, 32'h000000AA, 1'b0, 2, 0);
      txn("lb13", 32'h13, 32'h0, 1'b0, C_B, 32'hFFFFFFDE, 1'b0, 2, 0);
      txn("lbu10", 32'h10, 32'h0, 1'b0, C_BU, 32'h000000EF, 1'b0, 2, 0);

      // Half store into upper lane, lower lane preserved
      txn("sw20", 32'h20, 32'h55667788, 1'b1, C_W, 32'h0, 1'b0, 2, 0);
      txn("sh22", 32'h22, 32'h12348001, 1'b1, C_H, 32'h0, 1'b0, 3, 0);
      txn("lh22", 32'h22, 32'h0, 1'b0, C_H, 32'hFFFF8001, 1'b0, 2, 0);
      txn("lhu22", 32'h22, 32'h0, 1'b0, C_HU, 32'h00008001, 1'b0, 2, 0);
      txn("lh20", 32'h20, 32'h0, 1'b0, C_H, 32'h00007788, 1'b0, 2, 0);
      txn("lw20", 32'h20, 32'h0, 1'b0, C_W, 32'h80017788, 1'b0, 2, 0);

      // Misaligned accesses fault after one cycle and leave memory alone
      txn("lw13", 32'h13, 32'h0, 1'b0, C_W, 32'h0, 1'b1, 1, 0);
      txn("sh21", 32'h21, 32'h0000FFFF, 1'b1, C_H, 32'h0, 1'b1, 1, 0);
      txn("sw12", 32'h12, 32'h0, 1'b1, C_W, 32'h0, 1'b1, 1, 0);
      txn("lhu11", 32'h11, 32'h0, 1'b0, C_HU, 32'h0, 1'b1, 1, 0);
      txn("lw10c", 32'h10, 32'h0, 1'b0, C_W, 32'hDEADAAEF, 1'b0, 2, 0);
      txn("lw20c", 32'h20, 32'h0, 1'b0, C_W, 32'h80017788, 1'b0, 2, 0);

      // No-access codes: one-cycle response, no memory effect
      txn("none7", 32'h10, 32'h0, 1'b0, C_NONE, 32'h0, 1'b0, 1, 0);
      txn("none3st", 32'h10, 32'h0, 1'b1, 3'b011, 32'h0, 1'b0, 1, 0);
      txn("none6st", 32'h10, 32'h0, 1'b1, 3'b110, 32'h0, 1'b0, 1, 0);
      txn("lw10d", 32'h10, 32'h0, 1'b0, C_W, 32'hDEADAAEF, 1'b0, 2, 0);

      // Store with load-only codes behaves as SB / SH
      txn("sw40", 32'h40, 32'h11223344, 1'b1, C_W, 32'h0, 1'b0, 2, 0);
      txn("sbu42", 32'h42, 32'hFFFFFF99, 1'b1, C_BU, 32'h0, 1'b0, 3, 0);
      txn("lw40a", 32'h40, 32'h0, 1'b0, C_W, 32'h11993344, 1'b0, 2, 0);
      txn("shu40", 32'h40, 32'h5555ABCD, 1'b1, C_HU, 32'h0, 1'b0, 3, 0);
      txn("lw40b", 32'h40, 32'h0, 1'b0, C_W, 32'h1199ABCD, 1'b0, 2, 0);

      // Response held under back-pressure for five cycles
      txn("hold", 32'h10, 32'h0, 1'b0, C_W, 32'hDEADAAEF, 1'b0, 2, 5);
      txn("holdf", 32'h13, 32'h0, 1'b0, C_W, 32'h0, 1'b1, 1, 3);

      // Reset landing on the WRITE edge suppresses the write
      txn("sw30", 32'h30, 32'hCAFEF00D, 1'b1, C_W, 32'h0, 1'b0, 2, 0);
      req_valid = 1'b1;
      Address   = 32'h30;
      DataWr    = 32'h0BADBEEF;
      DMWr      = 1'b1;
      DMCtrl    = C_W;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rstwr.ready_in_write", 32'(req_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstwr.req_ready", 32'(req_ready), 32'd1);
      check("rstwr.resp_valid", 32'(resp_valid), 32'd0);
      check("rstwr.DataRd", DataRd, 32'd0);
      check("rstwr.fault", 32'(access_fault), 32'd0);
      txn("lw30", 32'h30, 32'h0, 1'b0, C_W, 32'hCAFEF00D, 1'b0, 2, 0);

      // Out-of-range address: fault or alias depending on the build
      txn("sw0", 32'h0, 32'h01020304, 1'b1, C_W, 32'h0, 1'b0, 2, 0);
`ifdef DMEM_RANGE_CHECK_EN
      txn("sw_oor", 32'(4 * DEPTH), 32'hFFFFFFFF, 1'b1, C_W, 32'h0, 1'b1, 1, 0);
      txn("lw0", 32'h0, 32'h0, 1'b0, C_W, 32'h01020304, 1'b0, 2, 0);
      txn("lw_oor_mis", 32'(4 * DEPTH) + 32'h3, 32'h0, 1'b0, C_W, 32'h0, 1'b1, 1, 0);
      txn("lw_oor", 32'(4 * DEPTH) + 32'h10, 32'h0, 1'b0, C_W, 32'h0, 1'b1, 1, 0);
`else
      txn("sw_oor", 32'(4 * DEPTH), 32'hFFFFFFFF, 1'b1, C_W, 32'h0, 1'b0, 2, 0);
      txn("lw0", 32'h0, 32'h0, 1'b0, C_W, 32'hFFFFFFFF, 1'b0, 2, 0);
      txn("lw_alias", 32'(4 * DEPTH) + 32'h10, 32'h0, 1'b0, C_W, 32'hDEADAAEF, 1'b0, 2, 0);
      txn("lw_hi", 32'h8000_0020, 32'h0, 1'b0, C_W, 32'h80017788, 1'b0, 2, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- Multi-cycle data memory responder at the far end of the decoder's DMWr/DMCtrl interface.
- Accepts one load/store request per handshake and performs byte, half or word access on a word-wide array.
- Handles sub-word stores by read-modify-write, and sign/zero-extends load data.
- Flags misaligned accesses without touching memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- IDX_W, $clog2(DEPTH_WORDS), word-index width; word index = Address[IDX_W+1:2].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- Address  input  32  byte address.
- DataWr  input  32  store data; byte/half taken from the low bits.
- DMWr  input  1  1 = store, 0 = load.
- DMCtrl  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; 111 = no access; 011/110 also treated as no access.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes the response.
- DataRd  output  32  load result; 0 for stores, no-access and faults.
- access_fault  output  1  response is a fault; qualified by resp_valid.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - State goes to IDLE; req_ready=1, resp_valid=0, DataRd=0, access_fault=0.
  - Array contents are not cleared.
  - Reset mid-operation aborts the operation. If rst coincides with the WRITE edge, the write is suppressed.
- States:
  - IDLE: req_ready=1.
  - READ: array read registered into rd_word.
  - WRITE: array written.
  - RESP: resp_valid=1.
- Accept: req_valid & req_ready at an edge. Address, DataWr, DMWr and DMCtrl are latched, and all later cycles use the latched copies.
- Transitions from IDLE on accept:
  - No-access code: go to RESP, DataRd=0, access_fault=0, no memory effect.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0): go to RESP, access_fault=1, DataRd=0, no write.
  - Load: READ, then RESP. DataRd is formed from rd_word by lane:
    - Byte lane = addr[1:0], half lane = addr[1].
    - B/H sign-extend; BU/HU zero-extend; W passes the word.
  - Store word: WRITE (full word), then RESP.
  - Store byte/half: READ, then WRITE (merge DataWr[7:0] or [15:0] into the selected lane of rd_word, other lanes unchanged), then RESP.
- Latency from accept edge to first resp_valid=1 cycle:
  - No-access/fault: 1 cycle.
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
- RESP handshake:
  - resp_valid, DataRd and access_fault are held stable until resp_ready=1 at an edge, then the unit returns to IDLE.
  - New requests are accepted only in IDLE, so the earliest next accept is the edge after the response handshake.
  - req_valid outside IDLE is ignored; the requester holds it.
- Address wrap: address bits above IDX_W+1 are ignored. Address 4*DEPTH_WORDS aliases word 0.
- DMWr=1 with a load-only code (100/101) is treated as SB/SH respectively.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined: any accepted access with Address[31:IDX_W+2]≠0 goes directly to RESP with access_fault=1, DataRd=0 and no write. Range check takes priority over the misalignment check.
- Undefined: upper bits are ignored, aliasing as described under Address wrap; access_fault reflects misalignment only.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → LW returns DataRd=0xDEADBEEF, access_fault=0; resp_valid 2 cycles after each accept.
- After the above, SB 0x000000AA @0x11, then LW @0x10 → DataRd=0xDEADAAEF; LB @0x11 → 0xFFFFFFAA; LBU @0x11 → 0x000000AA; SB response 3 cycles after accept.
- SH 0x12348001 @0x22, then LH @0x22 → 0xFFFF8001; LHU @0x22 → 0x00008001; LW @0x20 → upper half 0x8001, lower half unchanged.
- LW @0x13 and SH @0x21 → access_fault=1 after 1 cycle, DataRd=0; a following LW of those words shows the prior contents unchanged.
- Hold resp_ready=0 for 5 cycles in RESP → outputs stable and req_ready=0 throughout; assert rst during the WRITE of an SW to 0x30 → next cycle IDLE, resp_valid=0, and LW @0x30 returns the old value.
- DMEM_RANGE_CHECK_EN defined: SW @(4*DEPTH_WORDS) → access_fault=1 and word 0 unchanged. Undefined: the same SW overwrites word 0.
